uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. Captures each byte presented with the receiver's one-cycle done strobe and holds it until the consumer (bus interface or CPU peripheral register) pops it. Provides first-word-fall-through read data, occupancy count, almost-full warning and a sticky overrun flag, so that no byte is lost silently when the consumer is slow.

## Interface
Parameters:
- DATA_W, 8, byte width; matches the receiver data output.
- ADDR_W, 4, address bits; depth = 2^ADDR_W (16 entries).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2^ADDR_W.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset, asynchronous, active-high.
- wr  in  1  push strobe; driven by the receiver's done tick, one cycle per byte.
- w_data  in  DATA_W  byte to push; sampled when wr=1.
- rd  in  1  pop request; consumes the entry currently on r_data.
- clr_overrun  in  1  one-cycle clear of the overrun flag.
- r_data  out  DATA_W  oldest stored byte; valid only while empty=0.
- empty  out  1  no entries stored.
- full  out  1  count = 2^ADDR_W.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_W+1  number of stored entries, 0..2^ADDR_W.
- overrun  out  1  sticky; set when a push is dropped.

## Operation
- Storage: 2^ADDR_W x DATA_W register array, write pointer w_ptr and read pointer r_ptr (ADDR_W bits each, wrap modulo 2^ADDR_W), and an occupancy counter (ADDR_W+1 bits).
- Reset: w_ptr=0, r_ptr=0, count=0, overrun=0, storage cleared to 0. Output values in reset: empty=1, full=0, almost_full=0, count=0, overrun=0, r_data=0.
- Push: wr=1 and (full=0 or rd=1) -> mem[w_ptr]<=w_data, w_ptr<=w_ptr+1.
- Pop: rd=1 and empty=0 -> r_ptr<=r_ptr+1.
- Count update: push only +1; pop only -1; both or neither unchanged.
- Simultaneous cases:
  - empty, wr=1, rd=1: push only. Read is ignored. count becomes 1.
  - full, wr=1, rd=1: pop and push both occur. count stays 2^ADDR_W, overrun is not set.
  - full, wr=1, rd=0: byte dropped. Pointers and count unchanged. overrun<=1.
  - empty, rd=1, wr=0: ignored. No state change and no error flag.
- Overrun handling:
  - Set has priority over clear. If a drop occurs in the same cycle as clr_overrun=1, overrun stays 1.
  - Otherwise clr_overrun=1 clears overrun to 0 on the next edge.
- r_data = mem[r_ptr] (first-word-fall-through). When empty=1, r_data is the stale last-read location and must not be interpreted.
- empty, full, almost_full and overrun are decoded from registered state only. There is no combinational path from wr, rd or w_data to any output.
- Pointer wrap: after the push into entry 2^ADDR_W-1, w_ptr returns to 0, and likewise for r_ptr. Data order is preserved across the wrap.

## Timing
- Write-to-read latency is 1 cycle. After an edge with wr=1 into an empty FIFO, empty=0 and r_data=w_data are visible in the following cycle.
- A pop takes effect at the edge where rd=1. The next entry appears on r_data, or empty asserts, immediately after that edge.
- Full throughput is one push and one pop per cycle sustained.
- Flags and count update in the same cycle as the pointers. almost_full and full deassert on the edge of the pop that brings count below their thresholds.
- Asynchronous reset mid-operation immediately forces all outputs to their reset values, regardless of clk. All stored bytes are discarded. The first edge after reset release behaves as an empty FIFO.

## Test plan
- Reset then single byte: assert reset mid-stream, release, push 0xA5 -> next cycle empty=0, count=1, r_data=0xA5. Pop -> empty=1, count=0.
- Fill and order: push 0x00..0x0F with no pops, then pop 16 times:
  - almost_full rises at count=12.
  - full=1 at count=16.
  - Popped sequence is exactly 0x00..0x0F, then empty=1.
- Overrun: with FIFO full, push 0x55 -> overrun=1, count=16, and 0x55 never appears on r_data.
  - clr_overrun alone clears overrun.
  - A drop in the same cycle as clr_overrun leaves overrun=1.
- Simultaneous access:
  - Full with wr=rd=1 -> count stays 16, overrun=0, oldest byte popped, new byte last out.
  - Empty with wr=rd=1 -> count=1 and r_data = new byte.
- Wrap-around: 40 cycles of push 0x30+i with pops lagging by 3 -> all 40 bytes read back in order across two pointer wraps, and count never exceeds 4.
- Underflow: rd=1 for 3 cycles while empty -> pointers, count and overrun unchanged, and empty remains 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through FIFO
// with occupancy count, almost-full warning and a sticky overrun flag.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   wr, w_data        push strobe (receiver done tick) and byte
//   rd                pop the entry currently shown on r_data
//   clr_overrun       one-cycle clear of the overrun flag
//   r_data            oldest stored byte (valid while empty=0)
//   empty, full       occupancy flags
//   almost_full       count >= AF_LEVEL
//   count             stored entries, 0..2^ADDR_W
//   overrun           sticky, set when a push is dropped
module uart_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] r_data,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT =
    (ADDR_W+1)'(AF_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovr;

  logic push;
  logic pop;
  logic drop;

  // Flags come only from registered count, so no input
  // reaches an output combinationally.
  assign empty       = (cnt == '0);
  assign full        = (cnt == FULL_CNT);
  assign almost_full = (cnt >= AF_CNT);
  assign count       = cnt;
  assign overrun     = ovr;
  assign r_data      = mem[r_ptr];

  // When full, a same-cycle pop frees the slot the push
  // lands in; when empty, a read is simply ignored.
  assign push = wr & (~full | rd);
  assign pop  = rd & ~empty;
  assign drop = wr & full & ~rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[w_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (push)
        w_ptr <= w_ptr + 1'b1;
      if (pop)
        r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // A drop wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ovr <= 1'b0;
    else if (drop)
      ovr <= 1'b1;
    else if (clr_overrun)
      ovr <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue reference model,
// scoreboard of pushed bytes checked by a pop monitor.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] w_data = '0;
  logic       rd = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] count;
  logic       overrun;

  uart_rx_fifo #(
    .DATA_W(8), .ADDR_W(4), .AF_LEVEL(AF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr(wr),
    .w_data(w_data),
    .rd(rd),
    .clr_overrun(clr_overrun),
    .r_data(r_data),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .count(count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0] mq [$];
  logic [7:0] exp_q [$];
  bit         m_ovr = 1'b0;
  int         maxc;

  task automatic chk(input string nm,
                     input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Pop monitor: whenever the DUT really pops, the byte
  // on r_data must be the oldest one the model accepted.
  always @(negedge clk) begin
    if (!reset && rd && !empty) begin
      if (exp_q.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL pop_unexpected: got %0h expected none",
                 r_data);
      end else begin
        chk("pop_data", int'(r_data),
            int'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_count"}, int'(count), mq.size());
    chk({tag, "_empty"}, int'(empty),
        int'(mq.size() == 0));
    chk({tag, "_full"}, int'(full),
        int'(mq.size() == DEPTH));
    chk({tag, "_af"}, int'(almost_full),
        int'(mq.size() >= AF));
    chk({tag, "_ovr"}, int'(overrun), int'(m_ovr));
    if (mq.size() > 0)
      chk({tag, "_head"}, int'(r_data), int'(mq[0]));
  endtask

  // Called at posedge+1: drive, update model, step one edge, check.
  task automatic cycle(input string tag,
                       input logic w, input logic [7:0] d,
                       input logic r, input logic c);
    bit m_full;
    bit m_empty;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    wr = w;
    w_data = d;
    rd = r;
    clr_overrun = c;
    if (r && !m_empty)
      void'(mq.pop_front());
    if (w && (!m_full || r)) begin
      mq.push_back(d);
      exp_q.push_back(d);
    end
    if (w && m_full && !r)
      m_ovr = 1'b1;
    else if (c)
      m_ovr = 1'b0;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    clr_overrun = 1'b0;
    check_state(tag);
  endtask

  task automatic apply_reset();
    wr = 1'b0;
    rd = 1'b0;
    clr_overrun = 1'b0;
    #3 reset = 1'b1;
    #1;
    mq.delete();
    exp_q.delete();
    m_ovr = 1'b0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_rdata", int'(r_data), 0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (mq.size() > 0)
      cycle(tag, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic fill(input string tag);
    while (mq.size() < DEPTH)
      cycle(tag, 1'b1, 8'(mq.size()), 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    apply_reset();

    cycle("one", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("one_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    cycle("pre", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("pre", 1'b1, 8'h22, 1'b0, 1'b0);
    apply_reset();
    cycle("post", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("post_rdata", int'(r_data), 8'hA5);
    drain("post_pop");

    fill("fill");
    chk("fill_full", int'(full), 1);
    drain("order");

    fill("ovr_fill");
    cycle("ovr_drop", 1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovr_set", int'(overrun), 1);
    cycle("ovr_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovr_cleared", int'(overrun), 0);
    cycle("ovr_both", 1'b1, 8'h55, 1'b0, 1'b1);
    chk("ovr_prio", int'(overrun), 1);
    cycle("ovr_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    cycle("full_rw", 1'b1, 8'hC3, 1'b1, 1'b0);
    chk("full_rw_cnt", int'(count), DEPTH);
    drain("full_rw_drain");

    cycle("empty_rw", 1'b1, 8'h7E, 1'b1, 1'b0);
    chk("empty_rw_rdata", int'(r_data), 8'h7E);
    drain("empty_rw_drain");

    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("wrap", 1'b1, 8'(8'h30 + i),
            1'(i >= 3), 1'b0);
      if (int'(count) > maxc)
        maxc = int'(count);
    end
    chk("wrap_max_le4", int'(maxc <= 4), 1);
    drain("wrap_drain");

    for (int i = 0; i < 3; i++)
      cycle("under", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      cycle("rand",
            1'($urandom_range(0, 9) < 6),
            8'($urandom),
            1'($urandom_range(0, 9) < 4),
            1'($urandom_range(0, 9) == 0));
    drain("rand_drain");

    chk("leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
